// File: rtl/config_stream_loader.sv
// Bitstream-to-config-bus loader: parses {count, {tile,addr}, data, ...} words into tile config writes.
// Optional trailing XOR checksum word when CONFIG_STREAM_LOADER_CHECKSUM_EN is defined.
module config_stream_loader #(
    parameter int MAX_RECORDS = 65535,
    parameter int GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] tile_id,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_write,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] records_written
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HDR, S_DATA, S_ISSUE, S_GAP, S_FINISH, S_CHECK
    } state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state, next_state;
    logic [15:0]   rec_n;
    logic [GW-1:0] gap_cnt;
    logic          xfer;
    logic          last_rec;
    logic          over_max;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
    logic [31:0]   chk_xor;
`endif

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
    assign in_ready = (state == S_COUNT) || (state == S_HDR) || (state == S_DATA) ||
                      (state == S_CHECK);
`else
    assign in_ready = (state == S_COUNT) || (state == S_HDR) || (state == S_DATA);
`endif
    assign xfer     = in_valid && in_ready;
    assign last_rec = ({1'b0, records_written} + 17'd1) == {1'b0, rec_n};
    assign over_max = int'(in_word[15:0]) > MAX_RECORDS;

    always_comb begin
        next_state   = state;
        config_write = 1'b0;
        done         = 1'b0;
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE:   if (start) next_state = S_COUNT;
            S_COUNT: begin
                if (xfer) begin
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                    next_state = (in_word[15:0] == 16'd0) ? S_CHECK : S_HDR;
`else
                    next_state = (in_word[15:0] == 16'd0) ? S_FINISH : S_HDR;
`endif
                end
            end
            S_HDR:    if (xfer) next_state = S_DATA;
            S_DATA:   if (xfer) next_state = S_ISSUE;
            S_ISSUE: begin
                config_write = 1'b1;
                if (last_rec) begin
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                    next_state = S_CHECK;
`else
                    next_state = S_FINISH;
`endif
                end else begin
                    next_state = (GAP_CYCLES > 0) ? S_GAP : S_HDR;
                end
            end
            S_GAP:    if (gap_cnt == '0) next_state = S_HDR;
            S_CHECK:  if (xfer) next_state = S_FINISH;
            S_FINISH: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            rec_n           <= '0;
            gap_cnt         <= '0;
            tile_id         <= '0;
            config_addr     <= '0;
            config_data     <= '0;
            error           <= 1'b0;
            records_written <= '0;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
            chk_xor         <= '0;
`endif
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error           <= 1'b0;
                        records_written <= '0;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                        chk_xor         <= '0;
`endif
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        // Oversized counts are clamped so the load still runs to a bounded end.
                        if (over_max) begin
                            rec_n <= 16'(MAX_RECORDS);
                            error <= 1'b1;
                        end else begin
                            rec_n <= in_word[15:0];
                        end
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                        chk_xor <= chk_xor ^ in_word;
`endif
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        tile_id     <= in_word[31:16];
                        config_addr <= {16'd0, in_word[15:0]};
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                        chk_xor     <= chk_xor ^ in_word;
`endif
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        config_data <= in_word;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                        chk_xor     <= chk_xor ^ in_word;
`endif
                    end
                end
                S_ISSUE: begin
                    if (records_written != 16'hFFFF) records_written <= records_written + 16'd1;
                    gap_cnt <= GAP_LOAD;
                end
                S_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer && (in_word != chk_xor)) error <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader: stream-level model plus per-cycle compare process.
module tb_config_stream_loader;

    localparam int MAXR = 3;
    localparam int GAP  = 1;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [31:0] in_word;
    logic        in_ready, config_write, busy, done, error;
    logic [15:0] tile_id, records_written;
    logic [31:0] config_addr, config_data;

    config_stream_loader #(.MAX_RECORDS(MAXR), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .tile_id(tile_id), .config_addr(config_addr),
        .config_data(config_data), .config_write(config_write), .busy(busy), .done(done),
        .error(error), .records_written(records_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stream-level model: what the loader must do with the words it is handed.
    wq_t         stream;
    int          m_n, acc, wr_seen, quiet, cyc;
    bit          m_err, exp_wr, exp_done, mon_on;
    logic [15:0] cap_tile[$];
    logic [31:0] cap_addr[$], cap_data[$];
    int          cap_cyc[$];

    function automatic wq_t with_trailer(input wq_t w);
        wq_t r = w;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
        logic [31:0] x = '0;
        foreach (w[i]) x ^= w[i];
        r.push_back(x);
`endif
        return r;
    endfunction

    task automatic begin_load(input wq_t w);
        int raw;
        stream = w;
        raw    = int'(w[0][15:0]);
        m_n    = (raw > MAXR) ? MAXR : raw;
        m_err  = (raw > MAXR);
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
        begin
            logic [31:0] x = '0;
            for (int i = 0; i <= 2 * m_n; i++) x ^= w[i];
            if (w.size() > 2 * m_n + 1) m_err |= (w[2 * m_n + 1] != x);
            else m_err = 1'b1;
        end
`endif
        acc = 0; wr_seen = 0; quiet = 0; exp_wr = 0; exp_done = 0;
        cap_tile.delete(); cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
        mon_on = 1'b1;
    endtask

    always @(negedge clk) begin
        bit nwr, nd;
        int idx, total;
        cyc++;
        if (mon_on) begin
            nwr = 0; nd = 0;
            chk("config_write", config_write, exp_wr);
            chk("done", done, exp_done);
            if (config_write && wr_seen < m_n) begin
                chk("tile_id", tile_id, stream[2 * wr_seen + 1][31:16]);
                chk("config_addr", config_addr, {16'd0, stream[2 * wr_seen + 1][15:0]});
                chk("config_data", config_data, stream[2 * wr_seen + 2]);
                chk("in_ready_issue", in_ready, 0);
                chk("rec_at_issue", records_written, wr_seen);
                cap_tile.push_back(tile_id); cap_addr.push_back(config_addr);
                cap_data.push_back(config_data); cap_cyc.push_back(cyc);
            end
            if (done) begin
                chk("rec_at_done", records_written, m_n);
                chk("error_at_done", error, m_err);
                chk("busy_at_done", busy, 1);
                chk("in_ready_done", in_ready, 0);
            end
            if (quiet > 0) begin
                chk("in_ready_gap", in_ready, 0);
                quiet--;
            end
            if (config_write) begin
                wr_seen++;
                if (wr_seen == m_n) begin
`ifndef CONFIG_STREAM_LOADER_CHECKSUM_EN
                    nd = 1;
`endif
                end else quiet = GAP;
            end
            if (in_valid && in_ready) begin
                idx   = acc;
                acc++;
                total = 1 + 2 * m_n;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                total++;
`endif
                chk("accept_in_range", idx < total, 1);
                if (idx == 0) begin
`ifndef CONFIG_STREAM_LOADER_CHECKSUM_EN
                    if (m_n == 0) nd = 1;
`endif
                end else if (idx <= 2 * m_n) begin
                    if (idx % 2 == 0) nwr = 1;
                end else if (idx == 2 * m_n + 1) begin
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                    nd = 1;
`endif
                end
            end
            exp_wr   = nwr;
            exp_done = nd;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic feed(input wq_t w, input bit toggle, input int budget);
        int  i = 0;
        bit  ph = 1'b0;
        bit  taken;
        for (int c = 0; c < budget && i < w.size(); c++) begin
            in_valid = toggle ? ph : 1'b1;
            in_word  = w[i];
            ph       = !ph;
            @(negedge clk);
            taken = in_valid && in_ready;
            @(posedge clk); #1;
            if (taken) i++;
        end
        in_valid = 1'b0;
        if (i < w.size()) chk("feed_timeout", i, w.size());
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input wq_t w, input bit toggle);
        begin_load(w);
        pulse_start();
        feed(w, toggle, 200);
        wait_done();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_tile_id"}, tile_id, 0);
        chk({tag, "_addr"}, config_addr, 0);
        chk({tag, "_data"}, config_data, 0);
        chk({tag, "_write"}, config_write, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_rec"}, records_written, 0);
    endtask

    wq_t basic;

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_word = '0; mon_on = 1'b0; cyc = 0;
        #1 check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;

        // Basic load, in_valid held high
        basic = with_trailer('{32'd2, 32'h0003_0005, 32'hDEAD_BEEF, 32'h0007_0001, 32'h1234_5678});
        run(basic, 1'b0);
        chk("basic_nwrites", cap_tile.size(), 2);
        if (cap_tile.size() == 2) begin
            chk("basic_tile0", cap_tile[0], 16'd3);
            chk("basic_addr0", cap_addr[0], 32'd5);
            chk("basic_data0", cap_data[0], 32'hDEADBEEF);
            chk("basic_tile1", cap_tile[1], 16'd7);
            chk("basic_addr1", cap_addr[1], 32'd1);
            chk("basic_data1", cap_data[1], 32'h12345678);
            // issue, GAP_CYCLES of gap, header, data, issue
            chk("basic_spacing", cap_cyc[1] - cap_cyc[0], 3 + GAP);
        end
        chk("basic_rec", records_written, 16'd2);
        chk("basic_err", error, 0);
        chk("basic_hold_tile", tile_id, 16'd7);
        chk("basic_idle", busy, 0);

        // Backpressure
        run(basic, 1'b1);
        chk("bp_nwrites", cap_tile.size(), 2);
        if (cap_tile.size() == 2) begin
            chk("bp_data0", cap_data[0], 32'hDEADBEEF);
            chk("bp_tile1", cap_tile[1], 16'd7);
        end
        chk("bp_rec", records_written, 16'd2);

        // Zero count
        run(with_trailer('{32'hABCD_0000}), 1'b0);
        chk("zero_nwrites", cap_tile.size(), 0);
        chk("zero_rec", records_written, 16'd0);

        // Count above MAX_RECORDS is clamped and flagged
        run(with_trailer('{32'd5, 32'h0001_0010, 32'h11, 32'h0002_0020, 32'h22,
                           32'h0003_0030, 32'h33}), 1'b0);
        chk("clamp_rec", records_written, 16'd3);
        chk("clamp_err", error, 1);

        // Start pulsed during GAP is ignored; start also clears sticky error
        begin_load(basic);
        pulse_start();
        fork
            feed(basic, 1'b0, 200);
            begin
                bit hit = 1'b0;
                for (int c = 0; c < 50 && !hit; c++) begin
                    @(negedge clk);
                    hit = config_write;
                end
                chk("busy_start_found_write", hit, 1);
                @(posedge clk); #1 start = 1'b1;
                @(negedge clk); chk("busy_during_gap", busy, 1);
                @(posedge clk); #1 start = 1'b0;
            end
        join
        wait_done();
        @(negedge clk);
        chk("busy_start_nwrites", cap_tile.size(), 2);
        chk("busy_start_rec", records_written, 16'd2);
        chk("busy_start_err_cleared", error, 0);
        @(negedge clk);
        chk("busy_start_idle", busy, 0);

        // Reset while stalled in DATA
        begin_load(with_trailer('{32'd1, 32'h0009_000A, 32'h55}));
        pulse_start();
        feed('{32'd1, 32'h0009_000A}, 1'b0, 50);
        @(negedge clk); @(negedge clk);
        chk("stall_in_ready", in_ready, 1);
        chk("stall_tile", tile_id, 16'd9);
        mon_on = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        @(posedge clk); #1 reset = 1'b0;
        run(with_trailer('{32'd1, 32'h0004_0006, 32'hCAFE_F00D}), 1'b0);
        chk("after_reset_nwrites", cap_tile.size(), 1);
        chk("after_reset_rec", records_written, 16'd1);
        chk("after_reset_err", error, 0);

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
        run('{32'd1, 32'h0002_0004, 32'h0000_00FF, 32'h0002_00FA}, 1'b0);
        chk("cs_good_err", error, 0);
        chk("cs_good_rec", records_written, 16'd1);
        run('{32'd1, 32'h0002_0004, 32'h0000_00FF, 32'h0000_0000}, 1'b0);
        chk("cs_bad_err", error, 1);
        chk("cs_bad_rec", records_written, 16'd1);
`endif

        mon_on = 1'b0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
